// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S serializer: left/right 16-bit samples, one-bit delay, underrun and slot-length flags
module i2s_tx #(
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LRCLK,
  input  logic        SCLK,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  input  logic        vld,
  output logic        SDin,
  output logic        frm_ld,
  output logic        underrun,
  output logic        slot_err
);

  localparam int CNT_W = $clog2(SLOT_BITS + 1) + 1;
  localparam logic [CNT_W:0] SLOT_CNT = (CNT_W + 1)'(SLOT_BITS);

  logic                 lrclk_q;
  logic                 sclk_q;
  logic                 started;
  logic                 new_data;
  logic [15:0]          hold_lft;
  logic [15:0]          hold_rht;
  logic [SLOT_BITS-1:0] shifter;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W:0]       cnt_at_edge;

  logic lr_fall;
  logic lr_rise;
  logic lr_edge;
  logic sclk_fall;

  assign lr_fall     = ~LRCLK & lrclk_q;
  assign lr_rise     = LRCLK & ~lrclk_q;
  assign lr_edge     = lr_fall | lr_rise;
  assign sclk_fall   = ~SCLK & sclk_q;
  // A fall coincident with the LRCLK edge still belongs to the slot that is ending
  assign cnt_at_edge = {1'b0, cnt} + (CNT_W + 1)'(sclk_fall);

  function automatic logic [SLOT_BITS-1:0] slot_word(input logic [15:0] s);
    logic [DATA_BITS-1:0] dw;
    logic [SLOT_BITS-1:0] w;
    dw = '0;
    dw[DATA_BITS-1 -: 16] = s;
    w = '0;
    w[SLOT_BITS-1 -: DATA_BITS] = dw;
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_q  <= 1'b1;
      sclk_q   <= 1'b1;
      started  <= 1'b0;
      new_data <= 1'b0;
      hold_lft <= '0;
      hold_rht <= '0;
      shifter  <= '0;
      cnt      <= '0;
      SDin     <= 1'b0;
      frm_ld   <= 1'b0;
      underrun <= 1'b0;
      slot_err <= 1'b0;
    end else begin
      lrclk_q <= LRCLK;
      sclk_q  <= SCLK;
      frm_ld  <= lr_fall;

      if (vld) begin
        hold_lft <= lft_in;
        hold_rht <= rht_in;
      end

      if (lr_fall)
        new_data <= 1'b0;
      else if (vld)
        new_data <= 1'b1;

      if (lr_fall && !vld && !new_data)
        underrun <= 1'b1;

      if (lr_edge) begin
        started <= 1'b1;
        cnt     <= '0;
        if (started && cnt_at_edge != SLOT_CNT)
          slot_err <= 1'b1;
      end else if (sclk_fall && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      // Coincident vld bypasses the holding registers for the left word
      if (lr_fall)
        shifter <= vld ? slot_word(lft_in) : slot_word(hold_lft);
      else if (lr_rise)
        shifter <= slot_word(hold_rht);
      else if (sclk_fall && started)
        shifter <= {shifter[SLOT_BITS-2:0], 1'b0};

      if (sclk_fall)
        SDin <= (lr_edge || !started) ? 1'b0 : shifter[SLOT_BITS-1];
    end
  end

endmodule
